// File: rtl/dpi_mode_lock_ctrl.sv
// DPI acquisition lock controller: classifies FREQ/WIDTH measurements against a
// three-entry mode table, qualifies over consecutive matches and tracks lock loss.
module dpi_mode_lock_ctrl #(
  parameter int unsigned M0_FREQ        = 25175,
  parameter int unsigned M0_WIDTH       = 640,
  parameter int unsigned M1_FREQ        = 40000,
  parameter int unsigned M1_WIDTH       = 800,
  parameter int unsigned M2_FREQ        = 65000,
  parameter int unsigned M2_WIDTH       = 1024,
  parameter int unsigned HYST_FREQ      = 256,
  parameter int unsigned HYST_WIDTH     = 2,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned LOSS_COUNT     = 3,
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_meas_valid,
  input  logic [15:0] i_freq,
  input  logic [10:0] i_width,
  output logic        o_locked,
  output logic        o_dpi_en,
  output logic [1:0]  o_mode_idx,
  output logic        o_mode_change,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_QUALIFY = 2'd1,
    S_LOCKED  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  localparam logic [7:0]  LC   = 8'(LOCK_COUNT);
  localparam logic [7:0]  LS   = 8'(LOSS_COUNT);
  localparam logic [23:0] TO   = 24'(TIMEOUT_CYCLES);
  localparam logic [23:0] HO_M = 24'(HOLDOFF_CYCLES - 1);

  state_t      r_state, w_state_nx;
  logic [1:0]  r_cand, w_cand_nx;
  logic [7:0]  r_cnt, w_cnt_nx, w_cnt_inc;
  logic [7:0]  r_miss, w_miss_nx, w_miss_inc;
  logic [23:0] r_timer, w_timer_nx, w_timer_inc;
  logic [23:0] r_hold, w_hold_nx;
  logic        r_locked, w_locked_nx;
  logic        r_dpi_en;
  logic [1:0]  r_mode_idx, w_mode_nx;
  logic        r_mode_change, w_mc_nx;
  logic        w_hit;
  logic [1:0]  w_idx;
  logic [31:0] w_f32, w_w32;
  logic        w_m0, w_m1, w_m2;

  // Strict (exclusive) window test in 32-bit unsigned arithmetic.
  function automatic logic in_win(input logic [31:0] v, input logic [31:0] c,
                                  input logic [31:0] h);
    return (v > c - h) && (v < c + h);
  endfunction

  always_comb begin
    w_f32 = {16'd0, i_freq};
    w_w32 = {21'd0, i_width};
    w_m0  = in_win(w_f32, M0_FREQ, HYST_FREQ) && in_win(w_w32, M0_WIDTH, HYST_WIDTH);
    w_m1  = in_win(w_f32, M1_FREQ, HYST_FREQ) && in_win(w_w32, M1_WIDTH, HYST_WIDTH);
    w_m2  = in_win(w_f32, M2_FREQ, HYST_FREQ) && in_win(w_w32, M2_WIDTH, HYST_WIDTH);
    w_hit = w_m0 | w_m1 | w_m2;
    w_idx = w_m0 ? 2'd0 : (w_m1 ? 2'd1 : (w_m2 ? 2'd2 : 2'd0));
  end

  assign w_cnt_inc   = (r_cnt   == 8'hFF)     ? r_cnt   : r_cnt + 8'd1;
  assign w_miss_inc  = (r_miss  == 8'hFF)     ? r_miss  : r_miss + 8'd1;
  assign w_timer_inc = (r_timer == 24'hFFFFFF) ? r_timer : r_timer + 24'd1;

  always_comb begin
    w_state_nx  = r_state;
    w_cand_nx   = r_cand;
    w_cnt_nx    = r_cnt;
    w_miss_nx   = r_miss;
    w_timer_nx  = r_timer;
    w_hold_nx   = r_hold;
    w_locked_nx = r_locked;
    w_mode_nx   = r_mode_idx;
    w_mc_nx     = 1'b0;
    if (!i_enable) begin
      w_state_nx  = S_SEARCH;
      w_cand_nx   = 2'd0;
      w_cnt_nx    = 8'd0;
      w_miss_nx   = 8'd0;
      w_timer_nx  = 24'd0;
      w_hold_nx   = 24'd0;
      w_locked_nx = 1'b0;
    end else begin
      case (r_state)
        S_SEARCH: begin
          if (i_meas_valid && w_hit) begin
            w_cand_nx  = w_idx;
            w_cnt_nx   = 8'd1;
            w_state_nx = S_QUALIFY;
          end
        end
        S_QUALIFY: begin
          if (i_meas_valid) begin
            if (!w_hit) begin
              w_cnt_nx   = 8'd0;
              w_state_nx = S_SEARCH;
            end else if (w_idx == r_cand) begin
              w_cnt_nx = w_cnt_inc;
              if (w_cnt_inc >= LC) begin
                w_state_nx  = S_LOCKED;
                w_locked_nx = 1'b1;
                w_mode_nx   = r_cand;
                w_mc_nx     = 1'b1;
                w_miss_nx   = 8'd0;
                w_timer_nx  = 24'd0;
                w_cnt_nx    = 8'd0;
              end
            end else begin
              w_cand_nx = w_idx;
              w_cnt_nx  = 8'd1;
            end
          end
        end
        S_LOCKED: begin
          // Timeout outranks the measurement in the same cycle.
          if (w_timer_inc >= TO) begin
            w_state_nx  = S_HOLDOFF;
            w_locked_nx = 1'b0;
            w_hold_nx   = 24'd0;
            w_miss_nx   = 8'd0;
            w_timer_nx  = 24'd0;
          end else if (i_meas_valid) begin
            w_timer_nx = 24'd0;
            if (w_hit && (w_idx == r_mode_idx)) begin
              w_miss_nx = 8'd0;
            end else if (w_miss_inc >= LS) begin
              w_state_nx  = S_HOLDOFF;
              w_locked_nx = 1'b0;
              w_hold_nx   = 24'd0;
              w_miss_nx   = 8'd0;
            end else begin
              w_miss_nx = w_miss_inc;
            end
          end else begin
            w_timer_nx = w_timer_inc;
          end
        end
        S_HOLDOFF: begin
          if (r_hold >= HO_M) begin
            w_state_nx = S_SEARCH;
            w_hold_nx  = 24'd0;
            w_cnt_nx   = 8'd0;
          end else begin
            w_hold_nx = r_hold + 24'd1;
          end
        end
        default: w_state_nx = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_SEARCH;
      r_cand        <= 2'd0;
      r_cnt         <= 8'd0;
      r_miss        <= 8'd0;
      r_timer       <= 24'd0;
      r_hold        <= 24'd0;
      r_locked      <= 1'b0;
      r_dpi_en      <= 1'b0;
      r_mode_idx    <= 2'd0;
      r_mode_change <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cand        <= w_cand_nx;
      r_cnt         <= w_cnt_nx;
      r_miss        <= w_miss_nx;
      r_timer       <= w_timer_nx;
      r_hold        <= w_hold_nx;
      r_locked      <= w_locked_nx;
      r_dpi_en      <= w_locked_nx;
      r_mode_idx    <= w_mode_nx;
      r_mode_change <= w_mc_nx;
    end
  end

  assign o_locked      = r_locked;
  assign o_dpi_en      = r_dpi_en;
  assign o_mode_idx    = r_mode_idx;
  assign o_mode_change = r_mode_change;
  assign o_state       = r_state;

endmodule

// File: tb/tb_dpi_mode_lock_ctrl.sv
// Directed-vector bench for dpi_mode_lock_ctrl with hand-computed expectations.
module tb_dpi_mode_lock_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        meas_valid;
  logic [15:0] freq;
  logic [10:0] width;
  logic        locked;
  logic        dpi_en;
  logic [1:0]  mode_idx;
  logic        mode_change;
  logic [1:0]  state;

  int n_vec;
  int n_err;
  int cnt;

  dpi_mode_lock_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_enable      (enable),
    .i_meas_valid  (meas_valid),
    .i_freq        (freq),
    .i_width       (width),
    .o_locked      (locked),
    .o_dpi_en      (dpi_en),
    .o_mode_idx    (mode_idx),
    .o_mode_change (mode_change),
    .o_state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    enable     = 1'b1;
    meas_valid = 1'b0;
    freq       = 16'd0;
    width      = 11'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One-cycle strobe; returns on the negedge after the sampling edge.
  task automatic strobe(input logic [15:0] f, input logic [10:0] w);
    @(negedge clk);
    meas_valid = 1'b1;
    freq       = f;
    width      = w;
    @(negedge clk);
    meas_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // 1: reset state, lock on mode 0
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_locked", locked, 0);
    chk("rst_dpi_en", dpi_en, 0);
    chk("rst_mode", mode_idx, 0);
    chk("rst_mc", mode_change, 0);
    repeat (3) strobe(16'd25175, 11'd640);
    chk("t1_3rd_locked", locked, 0);
    chk("t1_3rd_state", state, 1);
    strobe(16'd25175, 11'd640);
    chk("t1_locked", locked, 1);
    chk("t1_dpi_en", dpi_en, 1);
    chk("t1_mc", mode_change, 1);
    chk("t1_mode", mode_idx, 0);
    chk("t1_state", state, 2);
    @(negedge clk);
    chk("t1_mc_pulse_end", mode_change, 0);

    // 2: window boundaries
    do_reset();
    strobe(16'd24919, 11'd640);
    chk("t2_f_lo_edge", state, 0);
    strobe(16'd25175, 11'd642);
    chk("t2_w_hi_edge", state, 0);
    strobe(16'd24920, 11'd641);
    chk("t2_inside", state, 1);

    // 3: candidate switch in QUALIFY
    do_reset();
    repeat (2) strobe(16'd40000, 11'd800);
    chk("t3_qual", state, 1);
    repeat (3) strobe(16'd65000, 11'd1024);
    chk("t3_no_lock_yet", locked, 0);
    strobe(16'd65000, 11'd1024);
    chk("t3_locked", locked, 1);
    chk("t3_mode", mode_idx, 2);
    chk("t3_mc", mode_change, 1);

    // 4: loss by consecutive misses, then holdoff
    do_reset();
    repeat (4) strobe(16'd40000, 11'd800);
    chk("t4_locked", locked, 1);
    chk("t4_mode", mode_idx, 1);
    repeat (2) strobe(16'd0, 11'd0);
    chk("t4_2miss", locked, 1);
    strobe(16'd40000, 11'd800);
    chk("t4_miss_clr", locked, 1);
    repeat (2) strobe(16'd0, 11'd0);
    chk("t4_2miss_b", locked, 1);
    strobe(16'd0, 11'd0);
    chk("t4_drop", locked, 0);
    chk("t4_drop_dpi", dpi_en, 0);
    chk("t4_holdoff", state, 3);
    cnt = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (state != 2'd3) break;
      cnt++;
      meas_valid = (i % 3 == 0);
      freq       = 16'd40000;
      width      = 11'd800;
    end
    meas_valid = 1'b0;
    chk("t4_holdoff_len", cnt, 1024);
    chk("t4_after_hold", state, 0);
    chk("t4_after_locked", locked, 0);
    chk("t4_no_mc", mode_change, 0);

    // 5: timeout after the last strobe
    do_reset();
    repeat (4) strobe(16'd25175, 11'd640);
    chk("t5_locked", locked, 1);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cnt++;
      if (!locked) break;
    end
    chk("t5_timeout_cycles", cnt, 100);
    chk("t5_state", state, 3);

    // 6: ENABLE low and async RESET
    do_reset();
    repeat (4) strobe(16'd65000, 11'd1024);
    chk("t6_locked2", locked, 1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    chk("t6_en_state", state, 0);
    chk("t6_en_locked", locked, 0);
    chk("t6_en_mode_kept", mode_idx, 2);
    repeat (2) strobe(16'd40000, 11'd800);
    chk("t6_qual", state, 1);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    chk("t6_en_qual_state", state, 0);
    chk("t6_en_qual_mode", mode_idx, 2);
    repeat (3) strobe(16'd65000, 11'd1024);
    chk("t6_relock_3", locked, 0);
    strobe(16'd65000, 11'd1024);
    chk("t6_relock_4", locked, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_async_locked", locked, 0);
    chk("t6_rst_async_dpi", dpi_en, 0);
    chk("t6_rst_mode", mode_idx, 0);
    chk("t6_rst_state", state, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) strobe(16'd40000, 11'd800);
    chk("t6_post_rst_3", locked, 0);
    strobe(16'd40000, 11'd800);
    chk("t6_post_rst_4", locked, 1);
    chk("t6_post_rst_mode", mode_idx, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
